// File: rtl/execute_mdu.sv
// Execute stage: operand select plus the single-cycle ALU, extended with an
// iterative RV32M multiply/divide unit that stalls the pipeline while it runs.

module exec_alu #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    input  logic [ALU_OP_W-1:0] op,
    output logic [XLEN-1:0]     y,
    output logic                f
);
    localparam int SH_W = (XLEN > 1) ? $clog2(XLEN) : 1;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_AND  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_OR   = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(9);
    localparam logic [ALU_OP_W-1:0] ALU_BEQ  = ALU_OP_W'(10);
    localparam logic [ALU_OP_W-1:0] ALU_BNE  = ALU_OP_W'(11);
    localparam logic [ALU_OP_W-1:0] ALU_BLT  = ALU_OP_W'(12);
    localparam logic [ALU_OP_W-1:0] ALU_BGE  = ALU_OP_W'(13);
    localparam logic [ALU_OP_W-1:0] ALU_BLTU = ALU_OP_W'(14);
    localparam logic [ALU_OP_W-1:0] ALU_BGEU = ALU_OP_W'(15);

    logic [SH_W-1:0] shamt;
    logic            lt_s;
    logic            lt_u;
    logic            eq;

    assign shamt = b[SH_W-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;
    assign eq    = a == b;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        y = a - b;
        f = 1'b0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLL:  y = a << shamt;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $signed(a) >>> shamt;
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, lt_u};
            ALU_BEQ:  f = eq;
            ALU_BNE:  f = ~eq;
            ALU_BLT:  f = lt_s;
            ALU_BGE:  f = ~lt_s;
            ALU_BLTU: f = lt_u;
            ALU_BGEU: f = ~lt_u;
            default:  y = '0;
        endcase
    end
endmodule

module execute_mdu #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst,
    input  logic                valid_i,
    input  logic                flush,
    input  logic [XLEN-1:0]     pc,
    input  logic [XLEN-1:0]     rD1,
    input  logic [XLEN-1:0]     rD2,
    input  logic [XLEN-1:0]     ext,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic                alua_sel,
    input  logic                alub_sel,
    input  logic                md_en,
    input  logic [2:0]          md_op,
    output logic [XLEN-1:0]     C,
    output logic                f,
    output logic                stall
);
    localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    // ---------------- single-cycle ALU path ----------------
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_y;
    logic            alu_f;

    assign alu_a = alua_sel ? rD1 : pc;
    assign alu_b = alub_sel ? rD2 : ext;

    exec_alu #(
        .XLEN     (XLEN),
        .ALU_OP_W (ALU_OP_W)
    ) u_alu (
        .a  (alu_a),
        .b  (alu_b),
        .op (alu_op),
        .y  (alu_y),
        .f  (alu_f)
    );

    // ---------------- multiply/divide state ----------------
    logic [1:0]      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]      op_q;
    logic            neg_res_q;   // negate product / quotient
    logic            neg_rem_q;   // remainder follows dividend sign
    logic [XLEN-1:0] mag_b_q;     // multiplicand or divisor magnitude
    logic [XLEN-1:0] hi_q;        // product high half or partial remainder
    logic [XLEN-1:0] lo_q;        // multiplier / dividend, shifts into product low / quotient
    logic [XLEN-1:0] result_q;

    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_val;
    logic            start;

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (md_op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
    end

    assign a_neg = a_signed & rD1[XLEN-1];
    assign b_neg = b_signed & rD2[XLEN-1];
    assign a_mag = a_neg ? -rD1 : rD1;
    assign b_mag = b_neg ? -rD2 : rD2;

    assign div_zero = md_op[2] & (rD2 == '0);
    assign div_ovf  = md_op[2] & ~md_op[0] & (rD1 == MIN_INT) & (rD2 == '1);
    assign special  = div_zero | div_ovf;

    // md_op[1] separates the remainder ops from the quotient ops
    always_comb begin
        if (div_zero)
            special_val = md_op[1] ? rD1 : '1;
        else
            special_val = md_op[1] ? '0 : rD1;
    end

    assign start = (state_q == IDLE) & valid_i & md_en & ~flush;

    // One iteration of each algorithm, computed from the current registers.
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     trial;
    logic              sub_ok;
    logic [XLEN-1:0]   hi_n;
    logic [XLEN-1:0]   lo_n;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fin_val;

    assign add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_b_q} : '0);
    assign trial   = {hi_q, lo_q[XLEN-1]} - {1'b0, mag_b_q};
    assign sub_ok  = ~trial[XLEN];

    always_comb begin
        if (op_q[2]) begin
            hi_n = sub_ok ? trial[XLEN-1:0] : {hi_q[XLEN-2:0], lo_q[XLEN-1]};
            lo_n = {lo_q[XLEN-2:0], sub_ok};
        end else begin
            hi_n = add_sum[XLEN:1];
            lo_n = {add_sum[0], lo_q[XLEN-1:1]};
        end
    end

    assign prod_s = neg_res_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    assign quo_s  = neg_res_q ? -lo_n : lo_n;
    assign rem_s  = neg_rem_q ? -hi_n : hi_n;

    always_comb begin
        case (op_q)
            OP_MUL:                       fin_val = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_val = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fin_val = quo_s;
            default:                      fin_val = rem_s;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mag_b_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            result_q  <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i && md_en) begin
                        op_q <= md_op;
                        if (special) begin
                            result_q <= special_val;
                            state_q  <= DONE;
                        end else begin
                            neg_res_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            mag_b_q   <= b_mag;
                            hi_q      <= '0;
                            lo_q      <= a_mag;
                            cnt_q     <= CNT_W'(XLEN - 1);
                            state_q   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    hi_q  <= hi_n;
                    lo_q  <= lo_n;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        result_q <= fin_val;
                        state_q  <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall = start | (state_q == BUSY);

    // M ops drive zero until their result is ready; ALU ops pass straight through.
    always_comb begin
        C = alu_y;
        f = alu_f;
        if (state_q == DONE) begin
            C = result_q;
            f = 1'b0;
        end else if (md_en) begin
            C = '0;
            f = 1'b0;
        end
    end
endmodule

// File: tb/tb_execute_mdu.sv
// Self-checking bench for execute_mdu: ALU path, M-extension results and
// latency via a scoreboard, divide special cases, flush and reset aborts.

module tb_execute_mdu;
    localparam int XLEN     = 32;
    localparam int ALU_OP_W = 4;

    logic                cpu_clk;
    logic                cpu_rst;
    logic                valid_i;
    logic                flush;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     rD1;
    logic [XLEN-1:0]     rD2;
    logic [XLEN-1:0]     ext;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alua_sel;
    logic                alub_sel;
    logic                md_en;
    logic [2:0]          md_op;
    logic [XLEN-1:0]     C;
    logic                f;
    logic                stall;

    execute_mdu #(
        .XLEN     (XLEN),
        .ALU_OP_W (ALU_OP_W)
    ) dut (
        .cpu_clk  (cpu_clk),
        .cpu_rst  (cpu_rst),
        .valid_i  (valid_i),
        .flush    (flush),
        .pc       (pc),
        .rD1      (rD1),
        .rD2      (rD2),
        .ext      (ext),
        .alu_op   (alu_op),
        .alua_sel (alua_sel),
        .alub_sel (alub_sel),
        .md_en    (md_en),
        .md_op    (md_op),
        .C        (C),
        .f        (f),
        .stall    (stall)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
        int          lat;
    } sb_item_t;

    sb_item_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one M instruction (called just after a rising edge) and hold it
    // until stall drops; the scoreboard supplies value and latency to compare.
    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        sb_item_t it;
        int cyc;
        it.tag = tag;
        it.val = exp;
        it.lat = lat;
        sb.push_back(it);
        valid_i  = 1'b1;
        md_en    = 1'b1;
        md_op    = op;
        rD1      = a;
        rD2      = b;
        alua_sel = 1'b0;
        alub_sel = 1'b0;
        pc       = 32'h0000_1234;
        ext      = 32'h0000_0FF0;
        alu_op   = 4'd0;
        cyc = 0;
        @(negedge cpu_clk);
        while (stall === 1'b1 && cyc < 100) begin
            @(negedge cpu_clk);
            cyc++;
        end
        if (sb.size() == 0) begin
            check({tag, " scoreboard"}, 32'd0, 32'd1);
        end else begin
            it = sb.pop_front();
            check({it.tag, " latency"}, 32'(cyc), 32'(it.lat));
            check({it.tag, " C"}, C, it.val);
            check({it.tag, " f"}, {31'b0, f}, 32'd0);
        end
        @(posedge cpu_clk);
        #1;
        valid_i = 1'b0;
        md_en   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] p;
        int bad;

        cpu_rst  = 1'b1;
        valid_i  = 1'b0;
        flush    = 1'b0;
        pc       = '0;
        rD1      = '0;
        rD2      = '0;
        ext      = '0;
        alu_op   = '0;
        alua_sel = 1'b1;
        alub_sel = 1'b1;
        md_en    = 1'b1;
        md_op    = '0;
        repeat (2) @(posedge cpu_clk);
        #1;
        cpu_rst = 1'b0;
        @(negedge cpu_clk);
        check("reset C", C, 32'd0);
        check("reset stall", {31'b0, stall}, 32'd0);
        check("reset f", {31'b0, f}, 32'd0);

        // ALU path
        @(posedge cpu_clk);
        #1;
        md_en = 1'b0; valid_i = 1'b1;
        alu_op = 4'd0; alua_sel = 1'b1; alub_sel = 1'b0; rD1 = 32'd5; ext = 32'd3;
        #1;
        check("alu add C", C, 32'd8);
        check("alu add stall", {31'b0, stall}, 32'd0);
        alua_sel = 1'b0; alub_sel = 1'b1; pc = 32'h100; rD2 = 32'd4;
        #1;
        check("alu pc+rD2", C, 32'h104);
        alu_op = 4'd10; alua_sel = 1'b1; rD1 = 32'd9; rD2 = 32'd9;
        #1;
        check("alu beq f", {31'b0, f}, 32'd1);
        @(negedge cpu_clk);
        check("alu stall edge", {31'b0, stall}, 32'd0);
        @(posedge cpu_clk);
        #1;
        valid_i = 1'b0;

        // Multiply
        run_md("MUL",    3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_md("MULH",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_md("MULHU",  3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_md("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);

        // Divide special cases
        run_md("DIV by0",  3'd4, 32'd7,         32'd0,         32'hFFFF_FFFF, 1);
        run_md("REMU by0", 3'd7, 32'd7,         32'd0,         32'd7,         1);
        run_md("DIV ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_md("REM ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Signed and unsigned divide
        run_md("DIV -7/2",  3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_md("REM -7/2",  3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_md("DIVU 100/7", 3'd5, 32'd100,      32'd7,         32'd14,        33);
        run_md("REMU 100/7", 3'd7, 32'd100,      32'd7,         32'd2,         33);
        run_md("DIV 7/-2",  3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_md("REM 7/-2",  3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         33);

        // Random unsigned cases against a bench-side model
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            p  = {32'd0, ra} * {32'd0, rb};
            run_md("MULHU rnd", 3'd3, ra, rb, p[63:32], 33);
            run_md("MUL rnd",   3'd0, ra, rb, p[31:0],  33);
            rb = rb >> (i * 8 + 4);
            if (rb == 0) rb = 32'd3;
            run_md("DIVU rnd", 3'd5, ra, rb, ra / rb, 33);
            run_md("REMU rnd", 3'd7, ra, rb, ra % rb, 33);
        end

        // Flush in cycle 10 of a DIV
        valid_i = 1'b1; md_en = 1'b1; md_op = 3'd4; rD1 = 32'd1000; rD2 = 32'd3;
        repeat (10) @(posedge cpu_clk);
        #1;
        flush = 1'b1;
        @(negedge cpu_clk);
        check("flush cycle stall", {31'b0, stall}, 32'd1);
        @(posedge cpu_clk);
        #1;
        flush = 1'b0; valid_i = 1'b0;
        @(negedge cpu_clk);
        check("after flush stall", {31'b0, stall}, 32'd0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge cpu_clk);
            if (stall !== 1'b0 || C !== 32'd0) bad++;
        end
        check("flush no result", 32'(bad), 32'd0);

        // Reset in cycle 5 of a MUL, then a fresh MUL
        @(posedge cpu_clk);
        #1;
        valid_i = 1'b1; md_en = 1'b1; md_op = 3'd0; rD1 = 32'd123; rD2 = 32'd456;
        repeat (5) @(posedge cpu_clk);
        #1;
        cpu_rst = 1'b1; valid_i = 1'b0;
        @(posedge cpu_clk);
        #1;
        cpu_rst = 1'b0;
        @(negedge cpu_clk);
        check("after rst C", C, 32'd0);
        check("after rst stall", {31'b0, stall}, 32'd0);
        @(posedge cpu_clk);
        #1;
        run_md("MUL 3x4", 3'd0, 32'd3, 32'd4, 32'd12, 33);

        check("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/execute_mdu.md
Name: execute_mdu

Overview:
Parametrised successor of the single-cycle execute stage. It keeps the A/B operand select and the existing ALU path, which completes in the same cycle. It adds an iterative RV32M multiply/divide unit that runs one bit per cycle. While that unit works it holds the pipeline through a stall handshake. It sits between the ID/EX and EX/MEM pipeline registers, and the hazard unit consumes its stall output.

Parameters:
XLEN, 32, datapath width; multiply/divide iteration count equals XLEN
ALU_OP_W, 4, width of alu_op; passed to the existing ALU instance unchanged

Ports:
cpu_clk  in  1  clock
cpu_rst  in  1  synchronous active-high reset
valid_i  in  1  EX holds a live instruction
flush  in  1  kill the current EX instruction (branch mispredict or trap)
pc  in  XLEN  instruction PC
rD1  in  XLEN  register operand 1
rD2  in  XLEN  register operand 2
ext  in  XLEN  immediate
alu_op  in  ALU_OP_W  ALU operation
alua_sel  in  1  1: A=rD1, 0: A=pc
alub_sel  in  1  1: B=rD2, 0: B=ext
md_en  in  1  instruction is RV32M
md_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
C  out  XLEN  execute result
f  out  1  ALU branch flag; 0 for M ops
stall  out  1  hold IF/ID/EX; EX/MEM inserts a bubble

Behaviour:
- md_en=0: A/B selected exactly as in the single-cycle stage; the existing ALU produces C and f combinationally; stall=0; FSM not involved.
- FSM states: IDLE, BUSY, DONE. Reset → IDLE, counter=0, result reg=0, C=0 (when md_en=0, C follows the ALU), stall=0.
- stall is combinational: (IDLE & valid_i & md_en & ~flush) | BUSY.
- IDLE → BUSY on valid_i & md_en & ~flush.
  - On that edge, latch operand magnitudes from rD1/rD2. alua_sel and alub_sel are ignored for M ops.
  - Latch the result-sign flags, md_op, and counter=XLEN-1.
  - Signedness: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats only rD1 as signed; MULHU/DIVU/REMU treat both as unsigned.
- Special cases go IDLE → DONE directly (latency 1), with no iteration:
  - Divide by zero (rD2=0): DIV/DIVU give all ones; REM/REMU give rD1.
  - Signed overflow (DIV/REM with rD1=2^(XLEN-1) and rD2=-1): DIV gives rD1; REM gives 0.
- BUSY operations, one per cycle:
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - Counter decrements each cycle; at counter=0 go BUSY → DONE and apply sign correction into the result reg.
- Sign rules:
  - Product: negate when the operand signs differ.
  - Quotient: negate when the operand signs differ.
  - Remainder: takes the dividend's sign.
- Result selection:
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits.
- DONE lasts one cycle: C=result reg, f=0, stall=0. The pipeline advances, and the FSM returns to IDLE the next cycle.
- Latency: request seen in cycle 0; stall is high in cycles 0..XLEN; result appears in cycle XLEN+1 (33 for XLEN=32). Special cases: stall in cycle 0, result in cycle 1.
- flush has priority over everything except reset. In any state the FSM goes to IDLE at the next edge; stall drops in the same cycle when in IDLE, otherwise in the next cycle; the partial result is discarded.
- A request in DONE cannot occur because stall=0 advances the pipeline. A back-to-back M instruction is accepted from IDLE in the following cycle.
- cpu_rst mid-operation behaves like flush and also clears all registers.

Test Plan:
- ADD path: md_en=0, alua_sel=1, alub_sel=0, rD1=5, ext=3 → C=8 in the same cycle; stall=0 throughout.
- MUL: rD1=7, rD2=0xFFFFFFFD → stall high for cycles 0..32; C=0xFFFFFFEB in cycle 33; stall=0 in cycle 33.
- MULH and MULHU: 0x80000000×0x80000000 → MULH gives 0x40000000; MULHU gives 0x40000000. MULHSU with rD1=0xFFFFFFFF, rD2=2 → 0xFFFFFFFF.
- Divide specials:
  - DIV 7/0 → C=0xFFFFFFFF in cycle 1.
  - REMU 7/0 → 7.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Signed divide: DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each completes in cycle 33.
- Abort cases:
  - flush asserted in cycle 10 of a DIV → FSM in IDLE next cycle, stall=0, no result is produced.
  - cpu_rst in cycle 5 → C=0, stall=0; a following MUL 3×4 gives 12 in cycle 33.
